// File: rtl/prog_interval_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prog_interval_timer : prescaled one-shot/periodic interval timer with pause
// Revision: 1.0
// ---------------------------------------------------------------------------
module prog_interval_timer #(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int TICK_HZ       = 1_000,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  input  logic                   one_shot,
  input  logic [COUNT_WIDTH-1:0] period,
  output logic                   timer_triggered,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] elapsed
);

  localparam int PRESCALE = CLK_FREQUENCY / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_prescale_check
    $error("prog_interval_timer: CLK_FREQUENCY/TICK_HZ must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          prescaler_q, prescaler_d;
  logic [COUNT_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   mode_q, mode_d;
  logic                   trig_q, trig_d;

  logic start_ok;
  logic tick;
  logic expire_hit;
  logic count_en;

  assign start_ok   = start && (period != '0);
  assign tick       = (prescaler_q == PRESCALE_MAX);
  assign expire_hit = tick && (elapsed_q == (period_q - 1'b1));

  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    elapsed_d   = elapsed_q;
    period_d    = period_q;
    mode_d      = mode_q;
    trig_d      = 1'b0;
    count_en    = 1'b0;

    // An expiry tick in RUN completes even if pause rises on that same cycle.
    case (state_q)
      RUN:     count_en = !pause || expire_hit;
      PAUSED:  count_en = !pause;
      default: count_en = 1'b0;
    endcase

    if (count_en) begin
      if (tick) begin
        prescaler_d = '0;
        if (expire_hit) begin
          elapsed_d = '0;
          trig_d    = 1'b1;
          if (mode_q) begin
            state_d = IDLE;
          end
        end else begin
          elapsed_d = elapsed_q + 1'b1;
        end
      end else begin
        prescaler_d = prescaler_q + 1'b1;
      end
    end

    if ((state_q != IDLE) && (state_d != IDLE)) begin
      state_d = pause ? PAUSED : RUN;
    end

    if (stop) begin
      trig_d = 1'b0;
      if (state_q != IDLE) begin
        state_d     = IDLE;
        prescaler_d = '0;
        elapsed_d   = '0;
      end
    end else if (start_ok) begin
      trig_d      = 1'b0;
      period_d    = period;
      mode_d      = one_shot;
      prescaler_d = '0;
      elapsed_d   = '0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      elapsed_q   <= '0;
      period_q    <= '0;
      mode_q      <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      elapsed_q   <= elapsed_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      trig_q      <= trig_d;
    end
  end

  assign timer_triggered = trig_q;
  assign running         = (state_q != IDLE);
  assign elapsed         = elapsed_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_interval_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prog_interval_timer : directed self-checking bench for prog_interval_timer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_prog_interval_timer;

  logic        clk;
  logic        reset;
  logic        start, stop, pause, one_shot;
  logic [15:0] period;
  logic        trig, running;
  logic [15:0] elapsed;

  logic        b_start, b_stop, b_pause, b_one_shot;
  logic [15:0] b_period;
  logic        b_trig, b_running;
  logic [15:0] b_elapsed;

  int n_checks;
  int n_fail;

  prog_interval_timer #(
    .CLK_FREQUENCY(8),
    .TICK_HZ      (2),
    .COUNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .pause          (pause),
    .one_shot       (one_shot),
    .period         (period),
    .timer_triggered(trig),
    .running        (running),
    .elapsed        (elapsed)
  );

  // Large-prescale instance (PRESCALE = 10_000).
  prog_interval_timer #(
    .CLK_FREQUENCY(50_000_000),
    .TICK_HZ      (5_000),
    .COUNT_WIDTH  (16)
  ) dut_big (
    .clk            (clk),
    .reset          (reset),
    .start          (b_start),
    .stop           (b_stop),
    .pause          (b_pause),
    .one_shot       (b_one_shot),
    .period         (b_period),
    .timer_triggered(b_trig),
    .running        (b_running),
    .elapsed        (b_elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig got %b want 0", trig); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL reset_elapsed got %0d want 0", elapsed); end
    n_checks++; if (b_running !== 1'b0) begin n_fail++; $display("FAIL reset_big_running got %b want 0", b_running); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_periodic();
    logic        exp_t;
    logic [15:0] exp_e;
    period = 16'd3; one_shot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      exp_t = (c == 12 || c == 24 || c == 36);
      exp_e = 16'((c / 4) % 3);
      n_checks++; if (trig !== exp_t) begin n_fail++; $display("FAIL periodic_trig cycle %0d got %b want %b", c, trig, exp_t); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL periodic_running cycle %0d got %b want 1", c, running); end
      n_checks++; if (elapsed !== exp_e) begin n_fail++; $display("FAIL periodic_elapsed cycle %0d got %0d want %0d", c, elapsed, exp_e); end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_one_shot();
    logic        exp_t, exp_r;
    logic [15:0] exp_e;
    period = 16'd2; one_shot = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      exp_t = (c == 8);
      exp_r = (c < 8);
      exp_e = (c < 8) ? 16'(c / 4) : 16'd0;
      n_checks++; if (trig !== exp_t) begin n_fail++; $display("FAIL oneshot_trig cycle %0d got %b want %b", c, trig, exp_t); end
      n_checks++; if (running !== exp_r) begin n_fail++; $display("FAIL oneshot_running cycle %0d got %b want %b", c, running, exp_r); end
      n_checks++; if (elapsed !== exp_e) begin n_fail++; $display("FAIL oneshot_elapsed cycle %0d got %0d want %0d", c, elapsed, exp_e); end
    end
    one_shot = 1'b0;
  endtask

  task automatic test_pause();
    logic exp_t;
    period = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      pause = (c >= 5 && c <= 14);
      step();
      exp_t = (c == 22);
      n_checks++; if (trig !== exp_t) begin n_fail++; $display("FAIL pause_trig cycle %0d got %b want %b", c, trig, exp_t); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL pause_running cycle %0d got %b want 1", c, running); end
      if (c >= 5 && c <= 14) begin
        n_checks++; if (elapsed !== 16'd1) begin n_fail++; $display("FAIL pause_hold cycle %0d got %0d want 1", c, elapsed); end
      end
    end
    pause = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;

    // Pause rising on the expiry tick: the pulse still fires, then time freezes.
    period = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      pause = (c >= 4 && c <= 10);
      step();
      exp_t = (c == 4 || c == 14);
      n_checks++; if (trig !== exp_t) begin n_fail++; $display("FAIL pause_expiry_trig cycle %0d got %b want %b", c, trig, exp_t); end
      n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL pause_expiry_elapsed cycle %0d got %0d want 0", c, elapsed); end
    end
    pause = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_zero_and_restart();
    logic exp_t, exp_r;
    for (int c = 0; c <= 24; c++) begin
      start  = (c == 0 || c == 3 || c == 10);
      period = (c == 0) ? 16'd0 : ((c == 3) ? 16'd5 : 16'd1);
      step();
      start = 1'b0;
      exp_t = (c == 14 || c == 18 || c == 22);
      exp_r = (c >= 3);
      n_checks++; if (trig !== exp_t) begin n_fail++; $display("FAIL restart_trig cycle %0d got %b want %b", c, trig, exp_t); end
      n_checks++; if (running !== exp_r) begin n_fail++; $display("FAIL restart_running cycle %0d got %b want %b", c, running, exp_r); end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_stop_reset();
    period = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) step();
    stop = 1'b1; start = 1'b1; period = 16'd2;
    step();
    stop = 1'b0; start = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stopstart_running got %b want 0", running); end
    n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL stopstart_elapsed got %0d want 0", elapsed); end
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++; if (trig !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL stopstart_idle cycle %0d got trig=%b run=%b want 0/0", c, trig, running); end
    end

    period = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) step();
    reset = 1'b1;
    step();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL midreset_trig got %b want 0", trig); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL midreset_running got %b want 0", running); end
    n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL midreset_elapsed got %0d want 0", elapsed); end
    start = 1'b1;
    step();
    start = 1'b0; reset = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_over_start got %b want 0", running); end
    for (int c = 0; c < 20; c++) begin
      step();
      n_checks++; if (trig !== 1'b0 || running !== 1'b0 || elapsed !== 16'd0) begin
        n_fail++; $display("FAIL postreset_idle cycle %0d got trig=%b run=%b el=%0d want 0/0/0", c, trig, running, elapsed);
      end
    end
  endtask

  task automatic test_large_prescale();
    int first, second, highs;
    first = -1; second = -1; highs = 0;
    b_period = 16'd2; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int c = 1; c <= 40002; c++) begin
      step();
      if (b_trig === 1'b1) begin
        highs++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    n_checks++; if (first != 20000) begin n_fail++; $display("FAIL big_first got %0d want 20000", first); end
    n_checks++; if (second != 40000) begin n_fail++; $display("FAIL big_second got %0d want 40000", second); end
    n_checks++; if (highs != 2) begin n_fail++; $display("FAIL big_width got %0d high cycles want 2", highs); end
    n_checks++; if (b_running !== 1'b1) begin n_fail++; $display("FAIL big_running got %b want 1", b_running); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; one_shot = 1'b0; period = 16'd0;
    b_start = 1'b0; b_stop = 1'b0; b_pause = 1'b0; b_one_shot = 1'b0; b_period = 16'd0;
    test_reset();
    test_periodic();
    test_one_shot();
    test_pause();
    test_zero_and_restart();
    test_stop_reset();
    test_large_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_interval_timer.md
Name: prog_interval_timer

Overview:
Run-time programmable interval timer: the generalised successor of the fixed-period timer. A compile-time prescaler derives a tick from the system clock. Period is loaded in ticks at start. The block supports one-shot and periodic modes, plus pause, stop and restart. It sits beside the motor/proximity control logic and supplies timeouts and periodic sample strobes.

Parameters:
CLK_FREQUENCY, 50_000_000, system clock rate in Hz.
TICK_HZ, 1_000, tick rate in Hz. PRESCALE = CLK_FREQUENCY/TICK_HZ (integer); elaboration must fail if PRESCALE < 1.
COUNT_WIDTH, 16, width of the period and elapsed counters, in ticks.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; clears all state.
start  input  1  single-cycle pulse; loads period/one_shot and (re)starts counting.
stop  input  1  single-cycle pulse; aborts the timer and returns to IDLE.
pause  input  1  level; while high in RUN, the prescaler and elapsed counter freeze.
one_shot  input  1  mode, sampled at an accepted start: 1 = single expiry, 0 = periodic.
period  input  COUNT_WIDTH  expiry interval in ticks, sampled at an accepted start.
timer_triggered  output  1  registered one-cycle expiry pulse.
running  output  1  high in RUN or PAUSED.
elapsed  output  COUNT_WIDTH  ticks completed in the current interval.

Behaviour:
- Reset: state=IDLE; prescaler=0; elapsed=0; timer_triggered=0; running=0; period_q=0; mode_q=0. Reset overrides every other input.
- States: IDLE, RUN, PAUSED.
- Start acceptance:
  - start with period==0 is ignored and the state is unchanged.
  - Otherwise start is accepted in any state. It latches period_q and mode_q, clears the prescaler and elapsed, and enters RUN.
  - A restart during RUN or PAUSED discards the interval in progress.
- Stop:
  - stop in RUN or PAUSED enters IDLE and clears the prescaler and elapsed. No pulse is produced.
  - stop and start in the same cycle: stop wins.
- Pause:
  - RUN->PAUSED when pause=1; PAUSED->RUN when pause=0.
  - The prescaler and elapsed hold while PAUSED. Remaining time is preserved exactly.
  - pause has no effect in IDLE.
- Counting in RUN with pause=0:
  - The prescaler increments each cycle and wraps at PRESCALE-1.
  - The tick condition is prescaler==PRESCALE-1.
  - On a tick, elapsed increments. If elapsed==period_q-1 on a tick, it is an expiry: elapsed becomes 0 and timer_triggered=1 on the next cycle only.
- Expiry timing: if start is accepted at edge E0 with no pause, the first timer_triggered is high between edges E0+N*PRESCALE and E0+N*PRESCALE+1, where N=period_q.
  - Periodic mode: further pulses every N*PRESCALE cycles.
  - One-shot mode: at the expiry edge the state goes to IDLE, so running falls in the same cycle the pulse rises.
- A pause asserted in the same cycle as an expiry tick: the expiry completes, and the pause takes effect from the next cycle.
- A start in the same cycle as an expiry: the restart wins and no pulse is produced.
- Arithmetic: all counters are unsigned and never exceed their bound. Maximum period is 2^COUNT_WIDTH-1 ticks. Changing period or one_shot while running has no effect until the next accepted start.

Test Plan:
1. CLK_FREQUENCY=8, TICK_HZ=2 (PRESCALE=4), periodic, period=3, start at edge 0 -> timer_triggered high only in cycles 12, 24 and 36; elapsed steps 0,1,2,0 on edges 4, 8, 12; running stays 1.
2. Same parameters, one_shot=1, period=2 -> single pulse in cycle 8; running 0 from cycle 8; no pulse by cycle 40.
3. Periodic, period=3: pause high on edges 5..14 (10 cycles) -> first pulse moves to cycle 22; elapsed holds at 1 while PAUSED.
4. start with period=0 in IDLE -> running stays 0, no pulse. Then start with period=5 at edge 3, restart with period=1 at edge 10 -> pulses at cycles 14, 18, 22, with none at 23.
5. stop and start in the same cycle during RUN -> IDLE, elapsed=0, no pulse. Reset asserted mid-interval -> all outputs 0 on the following cycle, and the block stays IDLE after release.
6. Defaults (PRESCALE=50_000), period=2 periodic -> pulses exactly 100_000 cycles apart, each exactly one cycle wide.
